vdc_timing_gen: RTL and testbench

Parametrised, CPU-programmable raster timing generator for the HuC6270 VDC model. It replaces hardcoded HSR/HDR/VSR/VDR/VCR constants with shadowed registers written over a simple register port, and generalises clocks-per-character and fetch lead. It adds a raster counter, RCR compare and vblank status with IRQ/acknowledge. It drives HSYNC_n/VSYNC_n and supplies the phase and fetch-window signals used by the BG/sprite fetch pipelines.

---
 rtl/vdc_pkg.sv | 30 +++
 rtl/vdc_phase_counter.sv | 56 +++++
 rtl/vdc_timing_gen.sv | 197 +++++++++++++++++++
 tb/tb_vdc_timing_gen.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdc_pkg.sv
// vdc_pkg: shared types and constants for the VDC raster timing generator.
// Phase enums, register map and control-register bit positions.
package vdc_pkg;

  typedef enum logic [1:0] {
    H_SYNC = 2'd0,
    H_WAIT = 2'd1,
    H_DISP = 2'd2,
    H_END  = 2'd3
  } h_state_t;

  typedef enum logic [1:0] {
    V_SYNC = 2'd0,
    V_WAIT = 2'd1,
    V_DISP = 2'd2,
    V_END  = 2'd3
  } v_state_t;

  localparam logic [2:0] REG_HSR = 3'd0;
  localparam logic [2:0] REG_HDR = 3'd1;
  localparam logic [2:0] REG_VSR = 3'd2;
  localparam logic [2:0] REG_VDR = 3'd3;
  localparam logic [2:0] REG_VCR = 3'd4;
  localparam logic [2:0] REG_RCR = 3'd5;
  localparam logic [2:0] REG_CR  = 3'd6;

  localparam int CR_RCR_EN = 2;
  localparam int CR_VD_EN  = 3;

endpackage

// File: rtl/vdc_phase_counter.sv
// vdc_phase_counter: generic 4-phase down-counter.
// On an advance with count 0 it steps to the next phase and loads its length.
module vdc_phase_counter #(
  parameter int               CNT_W   = 10,
  parameter logic [CNT_W-1:0] RST_CNT = '0
) (
  input  logic             clock,
  input  logic             reset_N,
  input  logic             i_adv,
  input  logic [CNT_W-1:0] i_ld_sync,
  input  logic [CNT_W-1:0] i_ld_wait,
  input  logic [CNT_W-1:0] i_ld_disp,
  input  logic [CNT_W-1:0] i_ld_end,
  output logic [1:0]       o_phase,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wrap
);

  logic [1:0]       r_phase;
  logic [1:0]       w_phase_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;

  assign o_wrap  = i_adv && (r_cnt == '0);
  assign o_phase = r_phase;
  assign o_cnt   = r_cnt;

  // next phase and reload on wrap, plain decrement on other advances
  always_comb begin
    w_phase_nx = r_phase;
    w_cnt_nx   = r_cnt;
    if (o_wrap) begin
      w_phase_nx = r_phase + 2'd1;
      unique case (r_phase)
        2'd0:    w_cnt_nx = i_ld_wait;
        2'd1:    w_cnt_nx = i_ld_disp;
        2'd2:    w_cnt_nx = i_ld_end;
        default: w_cnt_nx = i_ld_sync;
      endcase
    end else if (i_adv) begin
      w_cnt_nx = r_cnt - CNT_W'(1);
    end
  end

  // phase/count state register, starts in the sync phase
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_phase <= 2'd0;
      r_cnt   <= RST_CNT;
    end else begin
      r_phase <= w_phase_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

endmodule

// File: rtl/vdc_timing_gen.sv
// vdc_timing_gen: programmable HuC6270 raster timing with shadowed
// H/V registers, raster counter, RCR compare and vblank status/IRQ.
module vdc_timing_gen
  import vdc_pkg::*;
#(
  parameter int          CHAR_CLKS   = 8,
  parameter int          CNT_W       = 10,
  parameter int          RASTER_W    = 10,
  parameter int          RASTER_BASE = 64,
  parameter int          FETCH_LEAD  = 2,
  parameter logic [15:0] RST_HSR     = 16'h0202,
  parameter logic [15:0] RST_HDR     = 16'h031F,
  parameter logic [15:0] RST_VSR     = 16'h0F02,
  parameter logic [15:0] RST_VDR     = 16'h00EF,
  parameter logic [15:0] RST_VCR     = 16'h0003
) (
  input  logic                         clock,
  input  logic                         reset_N,
  input  logic                         reg_we,
  input  logic [2:0]                   reg_addr,
  input  logic [15:0]                  reg_wdata,
  input  logic                         irq_ack,
  output logic                         HSYNC_n,
  output logic                         VSYNC_n,
  output h_state_t                     h_state,
  output v_state_t                     v_state,
  output logic [$clog2(CHAR_CLKS)-1:0] char_cycle,
  output logic [RASTER_W-1:0]          raster,
  output logic                         in_vdw,
  output logic                         bg_fetch_en,
  output logic                         line_start,
  output logic                         frame_start,
  output logic [1:0]                   status,
  output logic                         IRQ_n
);

  localparam int CCW = $clog2(CHAR_CLKS);

  logic [15:0] r_hsr_s, r_hdr_s, r_vsr_s, r_vdr_s, r_vcr_s;
  logic [15:0] r_hsr_a, r_hdr_a, r_vsr_a, r_vdr_a, r_vcr_a;
  logic [15:0] r_rcr, r_cr;
  logic [15:0] w_hsr_nx, w_hdr_nx, w_vsr_nx, w_vdr_nx, w_vcr_nx;
  logic        w_wr_hsr, w_wr_hdr, w_wr_vsr, w_wr_vdr, w_wr_vcr;
  logic        w_wr_rcr, w_wr_cr;

  logic [CCW-1:0]      r_cc;
  logic [RASTER_W-1:0] r_raster;
  logic [1:0]          r_status;
  logic                r_line_start, r_frame_start;

  logic             w_ct, w_eol;
  logic [1:0]       w_h_ph, w_v_ph;
  logic [CNT_W-1:0] w_h_cnt, w_v_cnt;
  logic             w_h_wrap, w_v_wrap;
  logic             w_h_end_in;
  logic             w_v_disp_in, w_v_end_in, w_v_sync_in;
  logic             w_rr_set, w_vd_set;
  logic [CNT_W-1:0] w_v_ld_end;
  logic             w_unused;

  assign w_wr_hsr = reg_we && (reg_addr == REG_HSR);
  assign w_wr_hdr = reg_we && (reg_addr == REG_HDR);
  assign w_wr_vsr = reg_we && (reg_addr == REG_VSR);
  assign w_wr_vdr = reg_we && (reg_addr == REG_VDR);
  assign w_wr_vcr = reg_we && (reg_addr == REG_VCR);
  assign w_wr_rcr = reg_we && (reg_addr == REG_RCR);
  assign w_wr_cr  = reg_we && (reg_addr == REG_CR);

  // a write coinciding with the copy is forwarded into the active set
  assign w_hsr_nx = w_wr_hsr ? reg_wdata : r_hsr_s;
  assign w_hdr_nx = w_wr_hdr ? reg_wdata : r_hdr_s;
  assign w_vsr_nx = w_wr_vsr ? reg_wdata : r_vsr_s;
  assign w_vdr_nx = w_wr_vdr ? reg_wdata : r_vdr_s;
  assign w_vcr_nx = w_wr_vcr ? reg_wdata : r_vcr_s;

  assign w_ct  = &r_cc;
  assign w_eol = w_h_wrap && (w_h_ph == H_END);

  assign w_h_end_in  = w_h_wrap && (w_h_ph == H_DISP);
  assign w_v_disp_in = w_v_wrap && (w_v_ph == V_WAIT);
  assign w_v_end_in  = w_v_wrap && (w_v_ph == V_DISP);
  assign w_v_sync_in = w_v_wrap && (w_v_ph == V_END);

  assign w_v_ld_end = (r_vcr_a[7:0] == 8'd0) ? '0 :
                      CNT_W'(r_vcr_a[7:0]) - CNT_W'(1);

  vdc_phase_counter #(
    .CNT_W   (CNT_W),
    .RST_CNT (CNT_W'(RST_HSR[4:0]))
  ) u_h (
    .clock     (clock),
    .reset_N   (reset_N),
    .i_adv     (w_ct),
    .i_ld_sync (CNT_W'(w_hsr_nx[4:0])),
    .i_ld_wait (CNT_W'(r_hsr_a[14:8])),
    .i_ld_disp (CNT_W'(r_hdr_a[6:0])),
    .i_ld_end  (CNT_W'(r_hdr_a[11:8])),
    .o_phase   (w_h_ph),
    .o_cnt     (w_h_cnt),
    .o_wrap    (w_h_wrap)
  );

  vdc_phase_counter #(
    .CNT_W   (CNT_W),
    .RST_CNT (CNT_W'(RST_VSR[4:0]))
  ) u_v (
    .clock     (clock),
    .reset_N   (reset_N),
    .i_adv     (w_eol),
    .i_ld_sync (CNT_W'(w_vsr_nx[4:0])),
    .i_ld_wait (CNT_W'(r_vsr_a[15:8]) + CNT_W'(1)),
    .i_ld_disp (CNT_W'(r_vdr_a[8:0])),
    .i_ld_end  (w_v_ld_end),
    .o_phase   (w_v_ph),
    .o_cnt     (w_v_cnt),
    .o_wrap    (w_v_wrap)
  );

  // shadow registers and per-line / per-frame copies into active set
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_hsr_s <= RST_HSR;
      r_hdr_s <= RST_HDR;
      r_vsr_s <= RST_VSR;
      r_vdr_s <= RST_VDR;
      r_vcr_s <= RST_VCR;
      r_hsr_a <= RST_HSR;
      r_hdr_a <= RST_HDR;
      r_vsr_a <= RST_VSR;
      r_vdr_a <= RST_VDR;
      r_vcr_a <= RST_VCR;
      r_rcr   <= '0;
      r_cr    <= '0;
    end else begin
      r_hsr_s <= w_hsr_nx;
      r_hdr_s <= w_hdr_nx;
      r_vsr_s <= w_vsr_nx;
      r_vdr_s <= w_vdr_nx;
      r_vcr_s <= w_vcr_nx;
      if (w_wr_rcr) r_rcr <= reg_wdata;
      if (w_wr_cr)  r_cr  <= reg_wdata;
      if (w_eol) begin
        r_hsr_a <= w_hsr_nx;
        r_hdr_a <= w_hdr_nx;
      end
      if (w_v_sync_in) begin
        r_vsr_a <= w_vsr_nx;
        r_vdr_a <= w_vdr_nx;
        r_vcr_a <= w_vcr_nx;
      end
    end
  end

  assign w_rr_set = w_h_end_in && r_cr[CR_RCR_EN] &&
                    (r_raster == r_rcr[RASTER_W-1:0]);
  assign w_vd_set = w_v_end_in && r_cr[CR_VD_EN];

  // character phase, raster count, status bits and line/frame pulses
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      r_cc          <= '0;
      r_raster      <= '0;
      r_status      <= 2'b00;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_cc <= r_cc + CCW'(1);
      if (w_v_disp_in)
        r_raster <= RASTER_W'(RASTER_BASE);
      else if (w_eol)
        r_raster <= r_raster + RASTER_W'(1);
      r_status <= (irq_ack ? 2'b00 : r_status) | {w_vd_set, w_rr_set};
      r_line_start  <= w_eol;
      r_frame_start <= w_v_sync_in;
    end
  end

  assign h_state     = h_state_t'(w_h_ph);
  assign v_state     = v_state_t'(w_v_ph);
  assign HSYNC_n     = (w_h_ph != H_SYNC);
  assign VSYNC_n     = (w_v_ph != V_SYNC);
  assign char_cycle  = r_cc;
  assign raster      = r_raster;
  assign in_vdw      = (w_h_ph == H_DISP) && (w_v_ph == V_DISP);
  assign bg_fetch_en = ((w_h_ph == H_DISP) ||
                        ((w_h_ph == H_WAIT) &&
                         (w_h_cnt < CNT_W'(FETCH_LEAD)))) &&
                       (w_v_ph == V_DISP);
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign status      = r_status;
  assign IRQ_n       = ~|(r_status & {r_cr[CR_VD_EN], r_cr[CR_RCR_EN]});

  assign w_unused = ^{r_hsr_a, r_hdr_a, r_vsr_a, r_vdr_a, r_vcr_a,
                      r_rcr, r_cr, w_v_cnt};

endmodule

// File: tb/tb_vdc_timing_gen.sv
// tb_vdc_timing_gen: scoreboard bench for vdc_timing_gen.
// Expected output values are queued per cycle and compared as the DUT runs.
module tb_vdc_timing_gen;

  logic        clock     = 1'b0;
  logic        reset_N   = 1'b0;
  logic        reg_we    = 1'b0;
  logic [2:0]  reg_addr  = 3'd0;
  logic [15:0] reg_wdata = 16'd0;
  logic        irq_ack   = 1'b0;
  logic        HSYNC_n, VSYNC_n;
  logic [1:0]  h_state, v_state;
  logic [2:0]  char_cycle;
  logic [9:0]  raster;
  logic        in_vdw, bg_fetch_en, line_start, frame_start;
  logic [1:0]  status;
  logic        IRQ_n;

  typedef enum int {
    S_HS, S_VS, S_HST, S_VST, S_CC, S_RAS,
    S_VDW, S_BG, S_LS, S_FS, S_ST, S_IRQ
  } sel_t;

  typedef struct {
    int   k;
    sel_t s;
    int   e;
  } exp_t;

  exp_t sb[$];
  exp_t mx;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   c0    = 0;
  bit   mon_on = 1'b0;

  vdc_timing_gen dut (
    .clock       (clock),
    .reset_N     (reset_N),
    .reg_we      (reg_we),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .irq_ack     (irq_ack),
    .HSYNC_n     (HSYNC_n),
    .VSYNC_n     (VSYNC_n),
    .h_state     (h_state),
    .v_state     (v_state),
    .char_cycle  (char_cycle),
    .raster      (raster),
    .in_vdw      (in_vdw),
    .bg_fetch_en (bg_fetch_en),
    .line_start  (line_start),
    .frame_start (frame_start),
    .status      (status),
    .IRQ_n       (IRQ_n)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int kk();
    return cyc - c0;
  endfunction

  function automatic int sig(sel_t s);
    case (s)
      S_HS:    return int'(HSYNC_n);
      S_VS:    return int'(VSYNC_n);
      S_HST:   return int'(h_state);
      S_VST:   return int'(v_state);
      S_CC:    return int'(char_cycle);
      S_RAS:   return int'(raster);
      S_VDW:   return int'(in_vdw);
      S_BG:    return int'(bg_fetch_en);
      S_LS:    return int'(line_start);
      S_FS:    return int'(frame_start);
      S_ST:    return int'(status);
      default: return int'(IRQ_n);
    endcase
  endfunction

  function automatic string nm(sel_t s);
    case (s)
      S_HS:    return "hsync_n";
      S_VS:    return "vsync_n";
      S_HST:   return "h_state";
      S_VST:   return "v_state";
      S_CC:    return "char_cycle";
      S_RAS:   return "raster";
      S_VDW:   return "in_vdw";
      S_BG:    return "bg_fetch_en";
      S_LS:    return "line_start";
      S_FS:    return "frame_start";
      S_ST:    return "status";
      default: return "irq_n";
    endcase
  endfunction

  task automatic check_eq(string tag, int obs, int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_at(int k, sel_t s, int e);
    exp_t x;
    int   i;
    x.k = k;
    x.s = s;
    x.e = e;
    i = 0;
    while (i < sb.size() && sb[i].k <= k) i++;
    sb.insert(i, x);
  endtask

  always @(negedge clock) begin
    if (mon_on) begin
      while (sb.size() > 0 && sb[0].k <= kk()) begin
        mx = sb.pop_front();
        check_eq($sformatf("%s@%0d", nm(mx.s), mx.k), sig(mx.s), mx.e);
      end
    end
  end

  task automatic rst_vals(string p);
    check_eq({p, "_hsync_n"}, sig(S_HS), 0);
    check_eq({p, "_vsync_n"}, sig(S_VS), 0);
    check_eq({p, "_h_state"}, sig(S_HST), 0);
    check_eq({p, "_v_state"}, sig(S_VST), 0);
    check_eq({p, "_char_cycle"}, sig(S_CC), 0);
    check_eq({p, "_raster"}, sig(S_RAS), 0);
    check_eq({p, "_in_vdw"}, sig(S_VDW), 0);
    check_eq({p, "_bg_fetch"}, sig(S_BG), 0);
    check_eq({p, "_line_start"}, sig(S_LS), 0);
    check_eq({p, "_frame_start"}, sig(S_FS), 0);
    check_eq({p, "_status"}, sig(S_ST), 0);
    check_eq({p, "_irq_n"}, sig(S_IRQ), 1);
  endtask

  task automatic release_rst();
    @(negedge clock);
    reset_N = 1'b1;
    c0      = cyc;
    mon_on  = 1'b1;
  endtask

  task automatic wr(int at, logic [2:0] a, logic [15:0] d);
    while (kk() < at) @(negedge clock);
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(negedge clock);
    reg_we    = 1'b0;
  endtask

  task automatic ack(int at);
    while (kk() < at) @(negedge clock);
    irq_ack = 1'b1;
    @(negedge clock);
    irq_ack = 1'b0;
  endtask

  task automatic drain(int lim);
    while (sb.size() > 0 && kk() < lim) @(negedge clock);
    if (sb.size() > 0) begin
      check_eq("sb_drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not end, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    rst_vals("rst");

    // default timing: 42-char line, 263-line frame
    expect_at(1, S_CC, 1);
    expect_at(23, S_HS, 0);
    expect_at(24, S_HS, 1);
    expect_at(24, S_HST, 1);
    expect_at(48, S_HST, 2);
    expect_at(304, S_HST, 3);
    expect_at(335, S_LS, 0);
    expect_at(336, S_LS, 1);
    expect_at(336, S_HS, 0);
    expect_at(336, S_HST, 0);
    expect_at(336, S_RAS, 1);
    expect_at(337, S_LS, 0);
    expect_at(359, S_HS, 0);
    expect_at(360, S_HS, 1);
    expect_at(671, S_LS, 0);
    expect_at(672, S_LS, 1);
    expect_at(1007, S_VS, 0);
    expect_at(1008, S_VS, 1);
    expect_at(1008, S_VST, 1);
    expect_at(6719, S_RAS, 19);
    expect_at(6720, S_RAS, 64);
    expect_at(6720, S_VST, 2);
    expect_at(6751, S_BG, 0);
    expect_at(6752, S_BG, 1);
    expect_at(6767, S_VDW, 0);
    expect_at(6768, S_VDW, 1);
    expect_at(7023, S_VDW, 1);
    expect_at(7024, S_VDW, 0);
    expect_at(7024, S_BG, 0);
    expect_at(10383, S_ST, 0);
    expect_at(10383, S_IRQ, 1);
    expect_at(10384, S_ST, 1);
    expect_at(10384, S_IRQ, 0);
    expect_at(10391, S_ST, 0);
    expect_at(10391, S_IRQ, 1);
    expect_at(10720, S_ST, 1);
    expect_at(10721, S_ST, 1);
    expect_at(10721, S_IRQ, 0);

    release_rst();
    wr(2, 3'd5, 16'd74);
    wr(3, 3'd6, 16'h0004);
    ack(10390);
    wr(10395, 3'd5, 16'd75);
    ack(10719);
    drain(10800);

    while (kk() < 10730) @(negedge clock);
    #1 reset_N = 1'b0;
    #1 rst_vals("midrst");
    mon_on = 1'b0;
    repeat (3) @(negedge clock);

    // after reset: same first line, then reprogrammed line lengths
    expect_at(23, S_HS, 0);
    expect_at(24, S_HS, 1);
    expect_at(335, S_LS, 0);
    expect_at(336, S_LS, 1);
    expect_at(727, S_LS, 0);
    expect_at(728, S_LS, 1);
    expect_at(783, S_LS, 0);
    expect_at(784, S_LS, 1);
    expect_at(1735, S_RAS, 19);
    expect_at(1736, S_RAS, 64);
    expect_at(1736, S_VST, 2);
    expect_at(1743, S_BG, 0);
    expect_at(1744, S_BG, 1);
    expect_at(1751, S_VDW, 0);
    expect_at(1752, S_VDW, 1);
    expect_at(1783, S_VDW, 1);
    expect_at(1784, S_VDW, 0);
    expect_at(15120, S_RAS, 303);
    expect_at(15176, S_VST, 3);
    expect_at(15177, S_ST, 0);
    expect_at(15177, S_IRQ, 1);
    expect_at(15343, S_VST, 3);
    expect_at(15343, S_FS, 0);
    expect_at(15344, S_FS, 1);
    expect_at(15344, S_VS, 0);
    expect_at(15344, S_VST, 0);
    expect_at(15345, S_FS, 0);
    expect_at(29903, S_VST, 2);
    expect_at(29903, S_ST, 0);
    expect_at(29904, S_VST, 3);
    expect_at(29904, S_ST, 2);
    expect_at(29904, S_IRQ, 0);
    expect_at(29959, S_VST, 3);
    expect_at(29959, S_FS, 0);
    expect_at(29960, S_FS, 1);
    expect_at(29960, S_VST, 0);
    expect_at(29971, S_ST, 0);
    expect_at(29971, S_IRQ, 1);

    release_rst();
    wr(100, 3'd1, 16'h0227);
    wr(400, 3'd0, 16'h0000);
    wr(401, 3'd1, 16'h0003);
    wr(402, 3'd4, 16'h0000);
    wr(15400, 3'd6, 16'h0008);
    ack(29970);
    drain(30100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
